// File: rtl/axis_pkg.sv
// Shared AXI-Stream block definitions.
// FSM encodings and default stream width.
package axis_pkg;

    localparam int AXIS_DATA_W = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: rotate, take lowest set bit,
// rotate back. Search starts just after last_idx.
module rr_priority_pick #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [NUM_SRC-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               any_req
);

    int                    start;
    int                    hit;
    int                    pos;
    logic [2*NUM_SRC-1:0]  dbl_req;
    logic [2*NUM_SRC-1:0]  dbl_pick;
    logic [NUM_SRC-1:0]    rot;
    logic [NUM_SRC-1:0]    low;

    // rotate so the search start sits at bit 0, isolate, rotate back
    always_comb begin
        start    = (int'(last_idx) + 1) % NUM_SRC;
        dbl_req  = {req, req} >> start;
        rot      = dbl_req[NUM_SRC-1:0];
        low      = rot & (~rot + NUM_SRC'(1));
        dbl_pick = {low, low} << start;
        onehot   = dbl_pick[2*NUM_SRC-1:NUM_SRC];
        hit      = 0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (rot[i]) hit = i;
        end
        pos     = (start + hit) % NUM_SRC;
        idx     = IDX_W'(pos);
        any_req = |req;
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin AXI-Stream arbiter.
// Grant held from first beat to the TLAST handshake.
module axis_rr_arbiter
    import axis_pkg::*;
#(
    parameter  int NUM_SRC = 4,
    parameter  int DATA_W  = AXIS_DATA_W,
    localparam int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_SRC-1:0]        s_tvalid,
    input  logic [NUM_SRC*DATA_W-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]        s_tlast,
    output logic [NUM_SRC-1:0]        s_tready,
    output logic                      m_tvalid,
    output logic [DATA_W-1:0]         m_tdata,
    output logic                      m_tlast,
    input  logic                      m_tready,
    input  logic [NUM_SRC-1:0]        src_en,
    output logic [NUM_SRC-1:0]        grant,
    output logic                      busy,
    output logic                      pkt_done
);

    arb_state_e         state_q;
    arb_state_e         state_d;
    logic [NUM_SRC-1:0] grant_q;
    logic [IDX_W-1:0]   owner_q;
    logic [IDX_W-1:0]   last_idx_q;
    logic               pkt_done_q;
    logic [NUM_SRC-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               hs_last;

    rr_priority_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req      (s_tvalid & src_en),
        .last_idx (last_idx_q),
        .onehot   (pick_oh),
        .idx      (pick_idx),
        .any_req  (pick_any)
    );

    // state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // lock on any request, release on the TLAST handshake
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (pick_any) state_d = ST_LOCKED;
            ST_LOCKED: if (hs_last)  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // grant, owner and round-robin pointer bookkeeping
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant_q    <= '0;
            owner_q    <= '0;
            last_idx_q <= IDX_W'(NUM_SRC - 1);
            pkt_done_q <= 1'b0;
        end else begin
            pkt_done_q <= (state_q == ST_LOCKED) && hs_last;
            if (state_q == ST_IDLE && pick_any) begin
                grant_q <= pick_oh;
                owner_q <= pick_idx;
            end else if (state_q == ST_LOCKED && hs_last) begin
                grant_q    <= '0;
                last_idx_q <= owner_q;
            end
        end
    end

    // AND-OR mux of the owner's stream; zero grant idles everything
    always_comb begin
        m_tvalid = |(s_tvalid & grant_q);
        m_tlast  = |(s_tlast & grant_q);
        m_tdata  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            m_tdata = m_tdata
                    | (s_tdata[i*DATA_W +: DATA_W]
                       & {DATA_W{grant_q[i]}});
        end
        s_tready = grant_q & {NUM_SRC{m_tready}};
    end

    assign hs_last  = m_tvalid & m_tready & m_tlast;
    assign grant    = grant_q;
    assign busy     = (state_q == ST_LOCKED);
    assign pkt_done = pkt_done_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: directed scenarios
// plus random traffic against a packet-level model.
module tb_axis_rr_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           resetn;
    logic [N-1:0]   s_tvalid;
    logic [N*W-1:0] s_tdata;
    logic [N-1:0]   s_tlast;
    logic [N-1:0]   s_tready;
    logic           m_tvalid;
    logic [W-1:0]   m_tdata;
    logic           m_tlast;
    logic           m_tready;
    logic [N-1:0]   src_en;
    logic [N-1:0]   grant;
    logic           busy;
    logic           pkt_done;

    always #5 clk = ~clk;

    axis_rr_arbiter #(.NUM_SRC(N), .DATA_W(W)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .s_tvalid (s_tvalid),
        .s_tdata  (s_tdata),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .m_tvalid (m_tvalid),
        .m_tdata  (m_tdata),
        .m_tlast  (m_tlast),
        .m_tready (m_tready),
        .src_en   (src_en),
        .grant    (grant),
        .busy     (busy),
        .pkt_done (pkt_done)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // packet-level model: owner index, -1 when idle
    int           own   = -1;
    int           lastv = N - 1;
    logic         exp_done = 1'b0;
    logic [N-1:0] acc = '0;
    logic [N-1:0] eg, er, req;
    logic         ev, el;
    logic [W-1:0] ed;
    int           c;
    bit           found;

    // compare DUT against the model every cycle, then advance the model
    always @(negedge clk) begin
        if (!resetn) begin
            own = -1; lastv = N - 1; exp_done = 1'b0; acc = '0;
        end else begin
            eg = '0; ev = 1'b0; el = 1'b0; ed = '0; er = '0;
            if (own >= 0) begin
                eg = 4'b1 << own;
                ev = s_tvalid[own];
                el = s_tlast[own];
                ed = s_tdata[own*W +: W];
                if (m_tready) er = eg;
            end
            chk("mdl grant", 32'(grant), 32'(eg));
            chk("mdl busy", 32'(busy), 32'(own >= 0));
            chk("mdl pkt_done", 32'(pkt_done), 32'(exp_done));
            chk("mdl m_tvalid", 32'(m_tvalid), 32'(ev));
            chk("mdl m_tdata", 32'(m_tdata), 32'(ed));
            chk("mdl m_tlast", 32'(m_tlast), 32'(el));
            chk("mdl s_tready", 32'(s_tready), 32'(er));
            acc = er & s_tvalid;
            exp_done = 1'b0;
            if (own < 0) begin
                req = s_tvalid & src_en;
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    c = (lastv + k) % N;
                    if (!found && req[c]) begin
                        own = c; found = 1;
                    end
                end
            end else if (ev && m_tready && el) begin
                exp_done = 1'b1; lastv = own; own = -1;
            end
        end
    end

    task automatic at_drive(); @(posedge clk); #1; endtask
    task automatic at_sample(); @(negedge clk); #1; endtask

    task automatic set_src(input int i, input logic v,
                           input logic [W-1:0] d, input logic l);
        s_tvalid[i]      = v;
        s_tdata[i*W +: W] = d;
        s_tlast[i]       = l;
    endtask

    int           ord[$];
    logic [W-1:0] rx[$];
    int           bad;

    // run 1-beat contention until npkt grants are seen
    task automatic burst(input int npkt, output int ns);
        ord.delete(); ns = 0;
        for (int k = 0; k < 4 * npkt + 8; k++) begin
            at_sample(); ns++;
            if (grant != 0) begin
                ord.push_back($clog2(grant));
                if (ord.size() == npkt) break;
            end
            at_drive();
        end
        at_drive();
        s_tvalid = '0; s_tlast = '0;
    endtask

    // send an n-beat packet from one source, collect sink beats
    task automatic send(input string pfx, input int src, input int n,
                        input logic [W-1:0] base, input bit tog,
                        input bit clr);
        int  beat = 0;
        bit  hs;
        bit  done = 0;
        rx.delete(); bad = 0;
        set_src(src, 1'b1, base, n == 1);
        for (int cy = 0; cy < 40; cy++) begin
            at_sample();
            if (grant[src]) begin
                if ((s_tready & ~(4'b1 << src)) != 0) bad++;
                if (s_tready[src] !== m_tready) bad++;
            end
            if (m_tvalid && m_tready) rx.push_back(m_tdata);
            hs = s_tvalid[src] & s_tready[src];
            at_drive();
            if (clr && grant[src]) src_en[src] = 1'b0;
            if (hs) beat++;
            if (beat == n) begin
                set_src(src, 1'b0, '0, 1'b0);
                done = 1;
                break;
            end
            set_src(src, 1'b1, base + W'(beat), beat == n - 1);
            if (tog) m_tready = ~m_tready;
        end
        chk({pfx, " done"}, 32'(done), 1);
        chk({pfx, " beats"}, rx.size(), n);
        for (int k = 0; k < rx.size(); k++)
            chk({pfx, " data"}, 32'(rx[k]), 32'(base + W'(k)));
        chk({pfx, " tready"}, bad, 0);
    endtask

    int ns;
    int cnt[N];
    bit in_pkt[N];
    bit draining;

    initial begin
        #1000000;
        $display("FAIL watchdog: timeout reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; s_tvalid = '0; s_tdata = '0; s_tlast = '0;
        m_tready = 1'b0; src_en = '1; draining = 0;
        repeat (2) at_sample();
        chk("rst grant", 32'(grant), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst pkt_done", 32'(pkt_done), 0);
        chk("rst m_tvalid", 32'(m_tvalid), 0);
        chk("rst s_tready", 32'(s_tready), 0);

        // 1: source 2 sends 10,100,125
        at_drive();
        resetn = 1'b1; m_tready = 1'b1;
        set_src(2, 1'b1, 16'd10, 1'b0);
        at_sample(); chk("t1 idle grant", 32'(grant), 0);
        at_drive();
        at_sample();
        chk("t1 grant", 32'(grant), 32'h4);
        chk("t1 busy", 32'(busy), 1);
        chk("t1 d0", 32'(m_tdata), 10);
        chk("t1 s_tready", 32'(s_tready), 32'h4);
        at_drive(); set_src(2, 1'b1, 16'd100, 1'b0);
        at_sample(); chk("t1 d1", 32'(m_tdata), 100);
        at_drive(); set_src(2, 1'b1, 16'd125, 1'b1);
        at_sample();
        chk("t1 d2", 32'(m_tdata), 125);
        chk("t1 last", 32'(m_tlast), 1);
        at_drive(); set_src(2, 1'b0, '0, 1'b0);
        at_sample();
        chk("t1 pkt_done", 32'(pkt_done), 1);
        chk("t1 grant end", 32'(grant), 0);
        chk("t1 busy end", 32'(busy), 0);
        at_drive(); at_sample();
        chk("t1 pkt_done off", 32'(pkt_done), 0);

        // 2: all sources, 1-beat packets continuously
        at_drive();
        for (int i = 0; i < N; i++) set_src(i, 1'b1, W'(32 + i), 1'b1);
        burst(8, ns);
        chk("t2 count", ord.size(), 8);
        chk("t2 cycles", ns, 16);
        if (ord.size() > 0) chk("t2 first", ord[0], 3);
        for (int k = 0; k < ord.size(); k++)
            chk("t2 order", ord[k], (3 + k) % N);

        // 3: source 1, 4 beats, m_tready toggling
        at_drive();
        send("t3", 1, 4, 16'h11, 1'b1, 1'b0);
        m_tready = 1'b1;

        // 4: source 2 masked off
        src_en = 4'b1011;
        for (int i = 0; i < N; i++) set_src(i, 1'b1, W'(64 + i), 1'b1);
        burst(9, ns);
        for (int i = 0; i < N; i++) cnt[i] = 0;
        foreach (ord[k]) cnt[ord[k]]++;
        chk("t4 count", ord.size(), 9);
        chk("t4 src2", cnt[2], 0);
        chk("t4 src0", cnt[0], 3);
        chk("t4 src3", cnt[3], 3);
        src_en = '1;
        at_drive();
        send("t4b", 0, 3, 16'h50, 1'b0, 1'b1);
        at_sample();
        chk("t4b pkt_done", 32'(pkt_done), 1);
        at_drive(); src_en = '1;

        // 5: owner gap while another source waits
        set_src(3, 1'b1, 16'h70, 1'b0);
        at_sample(); chk("t5 idle", 32'(grant), 0);
        at_drive(); set_src(0, 1'b1, 16'h60, 1'b1);
        at_sample();
        chk("t5 grant", 32'(grant), 32'h8);
        chk("t5 d0", 32'(m_tdata), 32'h70);
        at_drive(); set_src(3, 1'b0, 16'h71, 1'b0);
        for (int i = 0; i < 5; i++) begin
            at_sample();
            chk("t5 gap grant", 32'(grant), 32'h8);
            chk("t5 gap busy", 32'(busy), 1);
            chk("t5 gap valid", 32'(m_tvalid), 0);
            at_drive();
        end
        set_src(3, 1'b1, 16'h71, 1'b1);
        at_sample();
        chk("t5 last grant", 32'(grant), 32'h8);
        chk("t5 last", 32'(m_tlast), 1);
        at_drive(); set_src(3, 1'b0, '0, 1'b0);
        at_sample(); chk("t5 gap idle", 32'(grant), 0);
        at_drive(); at_sample();
        chk("t5 src0 grant", 32'(grant), 32'h1);
        chk("t5 src0 data", 32'(m_tdata), 32'h60);
        at_drive(); set_src(0, 1'b0, '0, 1'b0);

        // 6: reset in the middle of a packet
        set_src(1, 1'b1, 16'h81, 1'b0);
        at_sample();
        at_drive();
        at_sample(); chk("t6 grant", 32'(grant), 32'h2);
        at_drive(); set_src(1, 1'b1, 16'h82, 1'b0);
        #3 resetn = 1'b0;
        #1;
        chk("t6 rst grant", 32'(grant), 0);
        chk("t6 rst busy", 32'(busy), 0);
        chk("t6 rst m_tvalid", 32'(m_tvalid), 0);
        chk("t6 rst s_tready", 32'(s_tready), 0);
        at_drive();
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) set_src(i, 1'b1, W'(96 + i), 1'b1);
        at_sample(); chk("t6 idle", 32'(grant), 0);
        at_drive(); at_sample();
        chk("t6 rearb", 32'(grant), 32'h1);
        at_drive(); s_tvalid = '0; s_tlast = '0;

        // random traffic, then drain
        for (int i = 0; i < N; i++) in_pkt[i] = 0;
        for (int cy = 0; cy < 3200; cy++) begin
            if (cy >= 3000 && !draining) begin
                draining = 1; src_en = '1;
            end
            for (int i = 0; i < N; i++) begin
                if (acc[i]) in_pkt[i] = !s_tlast[i];
                if (s_tvalid[i] && !acc[i]) begin
                end else if (draining && !in_pkt[i]) begin
                    set_src(i, 1'b0, '0, 1'b0);
                end else if ($urandom_range(0, 3) != 0) begin
                    set_src(i, 1'b1, W'($urandom),
                            draining || ($urandom_range(0, 3) == 0));
                end else begin
                    set_src(i, 1'b0, W'($urandom), 1'b0);
                end
            end
            m_tready = draining || ($urandom_range(0, 3) != 0);
            if (!draining && $urandom_range(0, 49) == 0)
                src_en = N'($urandom);
            if (draining && s_tvalid == 0 && grant == 0) break;
            at_drive();
        end
        chk("drain valid", 32'(s_tvalid), 0);
        chk("drain grant", 32'(grant), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
